// File: rtl/xcorr_lag_finder.sv
// xcorr_lag_finder
//   Estimates the inter-microphone delay (in samples) between two PCM streams.
//   A window of WIN_N samples per microphone is captured, then the time-domain
//   cross-correlation is evaluated for lags -MAX_LAG..+MAX_LAG with a single
//   multiply-accumulate per clock. The lag with the largest correlation is
//   reported with a one-cycle strobe, ready to drive the angle stage directly.
//
// Optional build macro:
//   XCORR_PEAK_GATE_EN - when defined, lag_valid is suppressed for windows whose
//                        best correlation is negative or not above PEAK_THRESH.
//                        lag_diff/peak_corr still update.
//
// Ports:
//   clk_60MHz     in   system clock
//   reset         in   asynchronous, active-high reset
//   enable        in   run enable (level); ignored once COMPUTE is entered
//   sample_valid  in   one-cycle strobe qualifying mic_a/mic_b
//   mic_a, mic_b  in   signed DATA_W samples
//   lag_diff      out  signed 6-bit best lag, positive = B lags A
//   lag_valid     out  one-cycle pulse, lag_diff/peak_corr updated this cycle
//   peak_corr     out  signed ACC_W correlation at the best lag
//   busy          out  high in CAPTURE or COMPUTE
//   overrun       out  one-cycle pulse when a sample is dropped during COMPUTE
module xcorr_lag_finder #(
  parameter int DATA_W      = 16,
  parameter int WIN_N       = 64,
  parameter int MAX_LAG     = 16,
  parameter int PEAK_THRESH = 0,
  localparam int ACC_W      = 2*DATA_W + $clog2(WIN_N)
) (
  input  logic                     clk_60MHz,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] mic_a,
  input  logic signed [DATA_W-1:0] mic_b,
  output logic signed [5:0]        lag_diff,
  output logic                     lag_valid,
  output logic signed [ACC_W-1:0]  peak_corr,
  output logic                     busy,
  output logic                     overrun
);

  localparam int PTR_W  = $clog2(WIN_N);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LAG_W  = 6;
  localparam int M      = WIN_N - 2*MAX_LAG;
  localparam int PROD_W = 2*DATA_W;
  localparam logic [ACC_W-1:0] THRESH = ACC_W'(PEAK_THRESH);

`ifdef XCORR_PEAK_GATE_EN
  localparam bit GATE_EN = 1'b1;
`else
  localparam bit GATE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CAPTURE, COMPUTE, REPORT} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] buf_a [WIN_N];
  logic signed [DATA_W-1:0] buf_b [WIN_N];

  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] n_cnt;    // position within the current lag, 0..M+1
  logic [LAG_W-1:0] lag_idx;  // current lag + MAX_LAG

  logic cap_wr, last_wr, issue_p0, lag_end, last_lag, ovr_hit, in_report;

  logic [PTR_W-1:0]         addr_a_p0, addr_b_p0;
  logic signed [DATA_W-1:0] rd_a_p1, rd_b_p1;
  logic                     vld_p1, vld_p2;
  logic signed [PROD_W-1:0] prod_p2;
  logic signed [ACC_W-1:0]  prod_ext_p2;
  logic signed [ACC_W-1:0]  acc, acc_sum;
  logic signed [ACC_W-1:0]  best_val;
  logic signed [LAG_W-1:0]  best_lag, cur_lag;
  logic                     peak_ok;

  // FSM: state register
  always_ff @(posedge clk_60MHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = CAPTURE;
      CAPTURE: begin
        if (!enable)     state_nxt = IDLE;
        else if (last_wr) state_nxt = COMPUTE;
      end
      COMPUTE: if (last_lag) state_nxt = REPORT;
      REPORT:  state_nxt = enable ? CAPTURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: output / control decode
  always_comb begin
    busy      = 1'b0;
    cap_wr    = 1'b0;
    issue_p0  = 1'b0;
    lag_end   = 1'b0;
    ovr_hit   = 1'b0;
    in_report = 1'b0;
    case (state)
      CAPTURE: begin
        busy   = 1'b1;
        // A sample arriving in the same cycle enable falls is discarded.
        cap_wr = sample_valid && enable;
      end
      COMPUTE: begin
        busy     = 1'b1;
        issue_p0 = (n_cnt < CNT_W'(M));
        // Two trailing cycles per lag let the read and multiply stages drain.
        lag_end  = (n_cnt == CNT_W'(M + 1));
        ovr_hit  = sample_valid;
      end
      REPORT:  in_report = 1'b1;
      default: ;
    endcase
    last_wr  = cap_wr && (wr_ptr == PTR_W'(WIN_N - 1));
    last_lag = lag_end && (lag_idx == LAG_W'(2*MAX_LAG));
  end

  always_ff @(posedge clk_60MHz or posedge reset) begin
    if (reset)                wr_ptr <= '0;
    else if (state != CAPTURE) wr_ptr <= '0;
    else if (cap_wr)          wr_ptr <= wr_ptr + 1'b1;
  end

  always_ff @(posedge clk_60MHz) begin
    if (cap_wr) begin
      buf_a[wr_ptr] <= mic_a;
      buf_b[wr_ptr] <= mic_b;
    end
  end

  always_ff @(posedge clk_60MHz or posedge reset) begin
    if (reset) begin
      n_cnt   <= '0;
      lag_idx <= '0;
    end else if (state != COMPUTE) begin
      n_cnt   <= '0;
      lag_idx <= '0;
    end else if (lag_end) begin
      n_cnt   <= '0;
      lag_idx <= lag_idx + 1'b1;
    end else begin
      n_cnt   <= n_cnt + 1'b1;
    end
  end

  // Stage p0: address generation. buf_a is read at n+MAX_LAG and buf_b at
  // n+MAX_LAG+L = n+lag_idx, so neither index leaves the window.
  assign addr_a_p0 = n_cnt[PTR_W-1:0] + PTR_W'(MAX_LAG);
  assign addr_b_p0 = n_cnt[PTR_W-1:0] + PTR_W'(lag_idx);

  // Stage p0 -> p1: registered buffer read
  always_ff @(posedge clk_60MHz) begin
    rd_a_p1 <= buf_a[addr_a_p0];
    rd_b_p1 <= buf_b[addr_b_p0];
  end

  // Stage p1 -> p2: registered multiply
  always_ff @(posedge clk_60MHz) begin
    prod_p2 <= rd_a_p1 * rd_b_p1;
  end

  always_ff @(posedge clk_60MHz or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= issue_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage p2: accumulate, and at the end of each lag compare against the best
  assign prod_ext_p2 = {{(ACC_W-PROD_W){prod_p2[PROD_W-1]}}, prod_p2};
  assign acc_sum     = acc + (vld_p2 ? prod_ext_p2 : '0);
  assign cur_lag     = $signed(lag_idx - LAG_W'(MAX_LAG));

  always_ff @(posedge clk_60MHz or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      best_val <= '0;
      best_lag <= '0;
    end else if (lag_end) begin
      acc <= '0;
      // Strictly-greater replacement keeps the most negative lag on ties.
      if (lag_idx == '0 || acc_sum > best_val) begin
        best_val <= acc_sum;
        best_lag <= cur_lag;
      end
    end else if (state == COMPUTE && vld_p2) begin
      acc <= acc_sum;
    end
  end

  // A negative peak never passes the gate regardless of the threshold.
  assign peak_ok = !best_val[ACC_W-1] && ($unsigned(best_val) > THRESH);

  always_ff @(posedge clk_60MHz or posedge reset) begin
    if (reset) begin
      lag_diff  <= '0;
      peak_corr <= '0;
      lag_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      lag_valid <= in_report && (!GATE_EN || peak_ok);
      overrun   <= ovr_hit;
      if (in_report) begin
        lag_diff  <= best_lag;
        peak_corr <= best_val;
      end
    end
  end

endmodule

// File: tb/tb_xcorr_lag_finder.sv
module tb_xcorr_lag_finder;

  localparam int DATA_W  = 16;
  localparam int WIN_N   = 64;
  localparam int MAX_LAG = 16;
  localparam int ACC_W   = 2*DATA_W + $clog2(WIN_N);
  localparam int M       = WIN_N - 2*MAX_LAG;
  localparam int LAT     = (2*MAX_LAG + 1)*(M + 2) + 2;

  logic                     clk_60MHz = 1'b0;
  logic                     reset = 1'b1;
  logic                     enable = 1'b0;
  logic                     sample_valid = 1'b0;
  logic signed [DATA_W-1:0] mic_a = '0;
  logic signed [DATA_W-1:0] mic_b = '0;
  logic signed [5:0]        lag_diff;
  logic                     lag_valid;
  logic signed [ACC_W-1:0]  peak_corr;
  logic                     busy;
  logic                     overrun;

  xcorr_lag_finder #(
    .DATA_W(DATA_W), .WIN_N(WIN_N), .MAX_LAG(MAX_LAG), .PEAK_THRESH(0)
  ) dut (
    .clk_60MHz(clk_60MHz), .reset(reset), .enable(enable),
    .sample_valid(sample_valid), .mic_a(mic_a), .mic_b(mic_b),
    .lag_diff(lag_diff), .lag_valid(lag_valid), .peak_corr(peak_corr),
    .busy(busy), .overrun(overrun)
  );

  always #8 clk_60MHz = ~clk_60MHz;

  int cyc = 0;
  always @(posedge clk_60MHz) cyc <= cyc + 1;

  typedef struct {
    int     cyc;
    int     lag;
    longint peak;
  } obs_t;

  obs_t obs_q[$];
  int   ovr_cnt = 0;
  int   dbl_cnt = 0;
  logic lv_prev = 1'b0;

  // Result monitor: records every lag_valid strobe for the main process.
  always @(negedge clk_60MHz) begin
    if (lag_valid) obs_q.push_back('{cyc, int'(lag_diff), longint'(peak_corr)});
    if (lag_valid && lv_prev) dbl_cnt <= dbl_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    lv_prev <= lag_valid;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  logic signed [DATA_W-1:0] src [WIN_N+8];
  logic signed [DATA_W-1:0] wa  [WIN_N];
  logic signed [DATA_W-1:0] wb  [WIN_N];

  // Window generator: a and b are the same noise stream, each delayed by da/db.
  task automatic gen_window(input int da, input int db, input bit zero);
    for (int k = 0; k < WIN_N + 8; k++) src[k] = DATA_W'($urandom);
    for (int n = 0; n < WIN_N; n++) begin
      wa[n] = zero ? '0 : src[n + 8 - da];
      wb[n] = zero ? '0 : src[n + 8 - db];
    end
  endtask

  function automatic longint corr_at(input int lag);
    longint s = 0;
    for (int n = 0; n < M; n++)
      s += longint'(wa[n + MAX_LAG]) * longint'(wb[n + MAX_LAG + lag]);
    return s;
  endfunction

  task automatic wait_obs(input int budget);
    int w = 0;
    while (obs_q.size() == 0 && w < budget) begin
      @(posedge clk_60MHz); #1;
      w++;
    end
  endtask

  task automatic run_window(input string nm, input int exp_lag,
                            input bit expect_pulse, input int inj);
    int     t_last = 0;
    int     ov0;
    longint ep;
    obs_t   o;
    ep = corr_at(exp_lag);
    enable = 1'b1;
    @(posedge clk_60MHz); #1;
    for (int i = 0; i < WIN_N; i++) begin
      sample_valid = 1'b1;
      mic_a = wa[i];
      mic_b = wb[i];
      t_last = cyc;
      @(posedge clk_60MHz); #1;
    end
    sample_valid = 1'b0;
    ov0 = ovr_cnt;
    for (int k = 0; k < inj; k++) begin
      repeat (20) @(posedge clk_60MHz);
      #1;
      sample_valid = 1'b1;
      mic_a = DATA_W'($urandom);
      mic_b = DATA_W'($urandom);
      @(posedge clk_60MHz); #1;
      sample_valid = 1'b0;
    end
    wait_obs(LAT + 100);
    if (expect_pulse) begin
      if (obs_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s timeout: no lag_valid within %0d cycles", nm, LAT + 100);
      end else begin
        o = obs_q.pop_front();
        check({nm, " lag_diff"}, o.lag, exp_lag);
        check({nm, " peak_corr"}, o.peak, ep);
        check({nm, " latency"}, o.cyc - t_last, LAT);
      end
    end else begin
      check({nm, " suppressed pulse"}, obs_q.size(), 0);
    end
    if (inj > 0) check({nm, " overrun pulses"}, ovr_cnt - ov0, inj);
    enable = 1'b0;
    repeat (2) @(posedge clk_60MHz);
    #1;
  endtask

  typedef struct {
    string nm;
    int    da;
    int    db;
    bit    zero;
    int    exp_lag;
    bit    pulse;
  } vec_t;

  vec_t vecs[4];

  initial begin
`ifdef XCORR_PEAK_GATE_EN
    vecs[3] = '{"zero", 0, 0, 1'b1, -16, 1'b0};
`else
    vecs[3] = '{"zero", 0, 0, 1'b1, -16, 1'b1};
`endif
    vecs[0] = '{"identical", 0, 0, 1'b0, 0, 1'b1};
    vecs[1] = '{"b_delay5", 0, 5, 1'b0, 5, 1'b1};
    vecs[2] = '{"a_delay3", 3, 0, 1'b0, -3, 1'b1};

    // Reset state
    repeat (3) @(posedge clk_60MHz);
    #1;
    check("reset lag_diff", lag_diff, 0);
    check("reset lag_valid", lag_valid, 0);
    check("reset peak_corr", peak_corr, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    reset = 1'b0;
    @(posedge clk_60MHz); #1;

    // Table-driven windows
    for (int v = 0; v < 4; v++) begin
      gen_window(vecs[v].da, vecs[v].db, vecs[v].zero);
      run_window(vecs[v].nm, vecs[v].exp_lag, vecs[v].pulse, 0);
    end

    // Two samples arriving during COMPUTE are dropped and flagged
    gen_window(0, 5, 1'b0);
    run_window("overrun_win", 5, 1'b1, 2);
    gen_window(3, 0, 1'b0);
    run_window("after_overrun", -3, 1'b1, 0);

    // enable dropped after 30 samples discards the partial window
    gen_window(0, 0, 1'b0);
    enable = 1'b1;
    @(posedge clk_60MHz); #1;
    for (int i = 0; i < 30; i++) begin
      sample_valid = 1'b1;
      mic_a = wa[i];
      mic_b = wb[i];
      @(posedge clk_60MHz); #1;
    end
    sample_valid = 1'b0;
    enable = 1'b0;
    repeat (LAT + 100) @(posedge clk_60MHz);
    #1;
    check("abort no lag_valid", obs_q.size(), 0);
    check("abort busy", busy, 0);
    gen_window(0, 5, 1'b0);
    run_window("after_abort", 5, 1'b1, 0);

    // Reset pulse in the middle of COMPUTE
    gen_window(0, 0, 1'b0);
    enable = 1'b1;
    @(posedge clk_60MHz); #1;
    for (int i = 0; i < WIN_N; i++) begin
      sample_valid = 1'b1;
      mic_a = wa[i];
      mic_b = wb[i];
      @(posedge clk_60MHz); #1;
    end
    sample_valid = 1'b0;
    repeat (300) @(posedge clk_60MHz);
    #1;
    reset = 1'b1;
    #1;
    check("midreset lag_diff", lag_diff, 0);
    check("midreset peak_corr", peak_corr, 0);
    check("midreset lag_valid", lag_valid, 0);
    check("midreset busy", busy, 0);
    check("midreset overrun", overrun, 0);
    @(posedge clk_60MHz); #1;
    reset = 1'b0;
    enable = 1'b0;
    repeat (LAT + 100) @(posedge clk_60MHz);
    #1;
    check("midreset no lag_valid", obs_q.size(), 0);
    gen_window(3, 0, 1'b0);
    run_window("after_reset", -3, 1'b1, 0);

    check("lag_valid back-to-back count", dbl_cnt, 0);
    check("unexpected lag_valid count", obs_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
